// File: rtl/book_replay_sequencer.sv
// Replays price snapshots into the order book: cancels each stock's resting order,
// then adds one order per stock at the snapshot price read from an external ROM.
module book_replay_sequencer #(
  parameter int NUM_STOCKS    = 4,
  parameter int NUM_SNAPSHOTS = 49,
  parameter int PRICE_W       = 16,
  parameter int ORDER_W       = 8,
  parameter int QTY_W         = 8,
  parameter int ORDER_QTY     = 1,
  parameter int ROM_LATENCY   = 2,
  parameter int INTERVAL_W    = 21,
  parameter int BUSY_TIMEOUT  = 4096,
  parameter int STOCK_W       = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
  parameter int SNAP_W        = (NUM_SNAPSHOTS > 1) ? $clog2(NUM_SNAPSHOTS) : 1
) (
  input  logic                      clk_100mhz,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      mode_auto,
  input  logic                      step_pulse,
  input  logic [INTERVAL_W-1:0]     interval,
  input  logic                      loop_en,
  output logic                      rom_rd_en,
  output logic [SNAP_W+STOCK_W-1:0] rom_addr,
  input  logic [PRICE_W-1:0]        rom_data,
  output logic                      start,
  output logic [2:0]                request,
  output logic                      delete,
  output logic [STOCK_W-1:0]        stock_to_add,
  output logic [PRICE_W-1:0]        price,
  output logic [ORDER_W-1:0]        order_id,
  output logic [QTY_W-1:0]          quantity,
  input  logic                      book_busy,
  output logic [SNAP_W-1:0]         snapshot_idx,
  output logic                      seq_busy,
  output logic                      done,
  output logic                      timeout_err,
  output logic [3:0]                state_dbg
);

  localparam logic [2:0] ADD_ORDER    = 3'd1;
  localparam logic [2:0] CANCEL_ORDER = 3'd2;

  localparam int LAT_W  = $clog2(ROM_LATENCY + 1);
  localparam int WAIT_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(ROM_LATENCY);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(BUSY_TIMEOUT - 1);
  localparam logic [STOCK_W-1:0] LAST_STOCK = STOCK_W'(NUM_STOCKS - 1);
  localparam logic [SNAP_W-1:0]  LAST_SNAP  = SNAP_W'(NUM_SNAPSHOTS - 1);
  localparam logic [ORDER_W-1:0] ID_ONE     = ORDER_W'(1);
  localparam logic [ORDER_W-1:0] ID_MAX     = '1;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    CANCEL_ISSUE = 4'd1,
    CANCEL_ARM   = 4'd2,
    CANCEL_WAIT  = 4'd3,
    FETCH        = 4'd4,
    FETCH_WAIT   = 4'd5,
    ADD_ISSUE    = 4'd6,
    ADD_ARM      = 4'd7,
    ADD_WAIT     = 4'd8,
    HOLD         = 4'd9,
    DONE         = 4'd10
  } state_t;

  state_t              state;
  logic [STOCK_W-1:0]  s;
  logic                populated;
  logic [ORDER_W-1:0]  cur_id;
  logic [ORDER_W-1:0]  prev_id;
  logic [ORDER_W-1:0]  next_id;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [LAT_W-1:0]    lat_cnt;
  logic [INTERVAL_W-1:0] timer;
  logic [INTERVAL_W-1:0] eff_interval;
  logic                advance;
  logic                wait_done;

  // Order ids live in 1..2^ORDER_W-1; zero is never handed to the book.
  assign prev_id      = (cur_id == ID_ONE) ? ID_MAX : cur_id - ID_ONE;
  assign next_id      = (cur_id == ID_MAX) ? ID_ONE : cur_id + ID_ONE;
  assign eff_interval = (interval == '0) ? INTERVAL_W'(1) : interval;
  assign advance      = run && (mode_auto ? (timer >= eff_interval) : step_pulse);
  assign wait_done    = !book_busy || (wait_cnt >= WAIT_LAST);

  assign seq_busy  = (state != IDLE) && (state != HOLD) && (state != DONE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state        <= IDLE;
      s            <= '0;
      populated    <= 1'b0;
      cur_id       <= ID_ONE;
      wait_cnt     <= '0;
      lat_cnt      <= '0;
      timer        <= '0;
      rom_rd_en    <= 1'b0;
      rom_addr     <= '0;
      start        <= 1'b0;
      request      <= '0;
      delete       <= 1'b0;
      stock_to_add <= '0;
      price        <= '0;
      order_id     <= '0;
      quantity     <= '0;
      snapshot_idx <= '0;
      timeout_err  <= 1'b0;
    end else begin
      start     <= 1'b0;
      rom_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            s <= '0;
            if (populated) begin
              start        <= 1'b1;
              request      <= CANCEL_ORDER;
              delete       <= 1'b1;
              stock_to_add <= '0;
              order_id     <= prev_id;
              wait_cnt     <= '0;
              state        <= CANCEL_ISSUE;
            end else begin
              state <= FETCH;
            end
          end
        end
        CANCEL_ISSUE: state <= CANCEL_ARM;
        CANCEL_ARM:   state <= CANCEL_WAIT;
        CANCEL_WAIT: begin
          if (wait_done) begin
            if (book_busy) timeout_err <= 1'b1;
            if (s == LAST_STOCK) begin
              s     <= '0;
              state <= FETCH;
            end else begin
              s            <= s + STOCK_W'(1);
              start        <= 1'b1;
              request      <= CANCEL_ORDER;
              delete       <= 1'b1;
              stock_to_add <= s + STOCK_W'(1);
              order_id     <= prev_id;
              wait_cnt     <= '0;
              state        <= CANCEL_ISSUE;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        FETCH: begin
          rom_rd_en <= 1'b1;
          rom_addr  <= {snapshot_idx, s};
          lat_cnt   <= '0;
          state     <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          // lat_cnt counts from the cycle the read strobe is visible to the ROM.
          if (lat_cnt == LAT_LAST) begin
            price        <= rom_data;
            start        <= 1'b1;
            request      <= ADD_ORDER;
            delete       <= 1'b0;
            stock_to_add <= s;
            order_id     <= cur_id;
            quantity     <= QTY_W'(ORDER_QTY);
            wait_cnt     <= '0;
            state        <= ADD_ISSUE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        ADD_ISSUE: state <= ADD_ARM;
        ADD_ARM:   state <= ADD_WAIT;
        ADD_WAIT: begin
          if (wait_done) begin
            if (book_busy) timeout_err <= 1'b1;
            if (s == LAST_STOCK) begin
              s         <= '0;
              populated <= 1'b1;
              cur_id    <= next_id;
              timer     <= '0;
              state     <= HOLD;
            end else begin
              s     <= s + STOCK_W'(1);
              state <= FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        HOLD: begin
          if (advance) begin
            if ((snapshot_idx != LAST_SNAP) || loop_en) begin
              snapshot_idx <= (snapshot_idx == LAST_SNAP) ? '0 : snapshot_idx + SNAP_W'(1);
              start        <= 1'b1;
              request      <= CANCEL_ORDER;
              delete       <= 1'b1;
              stock_to_add <= s;
              order_id     <= prev_id;
              wait_cnt     <= '0;
              state        <= CANCEL_ISSUE;
            end else begin
              request      <= '0;
              delete       <= 1'b0;
              stock_to_add <= '0;
              price        <= '0;
              order_id     <= '0;
              quantity     <= '0;
              state        <= DONE;
            end
          end else if (run && (timer != '1)) begin
            timer <= timer + INTERVAL_W'(1);
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_book_replay_sequencer.sv
// Directed bench for book_replay_sequencer: ROM and book models, command
// scoreboard, manual/auto stepping, looping, busy timeout and mid-command reset.
`timescale 1ns/1ps
module tb_book_replay_sequencer;

  localparam int NS     = 4;
  localparam int NSNAP  = 3;
  localparam int LAT    = 2;
  localparam int TO     = 16;
  localparam int SW     = 2;
  localparam int SNW    = 2;
  localparam int CMD_W  = 38;
  localparam logic [2:0] ADD_ORDER    = 3'd1;
  localparam logic [2:0] CANCEL_ORDER = 3'd2;
  localparam logic [3:0] S_ADD_WAIT   = 4'd8;
  localparam logic [3:0] S_HOLD       = 4'd9;

  logic              clk_100mhz = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic              mode_auto = 1'b0;
  logic              step_pulse = 1'b0;
  logic [20:0]       interval = '0;
  logic              loop_en = 1'b1;
  logic              rom_rd_en;
  logic [SNW+SW-1:0] rom_addr;
  logic [15:0]       rom_data = '0;
  logic [15:0]       rom_d1 = '0;
  logic              start;
  logic [2:0]        request;
  logic              delete;
  logic [SW-1:0]     stock_to_add;
  logic [15:0]       price;
  logic [7:0]        order_id;
  logic [7:0]        quantity;
  logic              book_busy = 1'b0;
  logic [SNW-1:0]    snapshot_idx;
  logic              seq_busy;
  logic              done;
  logic              timeout_err;
  logic [3:0]        state_dbg;

  int busy_mode = 0;
  int busy_left = 0;
  int overlap_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [CMD_W-1:0] exp_q[$];
  logic [CMD_W-1:0] obs_q[$];

  book_replay_sequencer #(
    .NUM_STOCKS(NS), .NUM_SNAPSHOTS(NSNAP), .PRICE_W(16), .ORDER_W(8), .QTY_W(8),
    .ORDER_QTY(1), .ROM_LATENCY(LAT), .INTERVAL_W(21), .BUSY_TIMEOUT(TO)
  ) dut (
    .clk_100mhz(clk_100mhz), .rst(rst), .run(run), .mode_auto(mode_auto),
    .step_pulse(step_pulse), .interval(interval), .loop_en(loop_en),
    .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .start(start), .request(request), .delete(delete), .stock_to_add(stock_to_add),
    .price(price), .order_id(order_id), .quantity(quantity), .book_busy(book_busy),
    .snapshot_idx(snapshot_idx), .seq_busy(seq_busy), .done(done),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk_100mhz = ~clk_100mhz;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rom_price(input int snap, input int stk);
    return 16'((snap + 1) * 256 + (stk + 1) * 17);
  endfunction

  // Price ROM: data is non-zero only in the single cycle LAT after the strobe.
  always @(posedge clk_100mhz) begin
    rom_d1   <= rom_rd_en ? rom_price(int'(rom_addr[SNW+SW-1:SW]), int'(rom_addr[SW-1:0])) : 16'h0;
    rom_data <= rom_d1;
  end

  // Book: 0 = never busy, 1 = busy 10 cycles after each start, 2 = stuck busy.
  always @(posedge clk_100mhz) begin
    if (start && book_busy) overlap_cnt <= overlap_cnt + 1;
    if (busy_mode == 2) begin
      book_busy <= 1'b1;
      busy_left <= 0;
    end else if (busy_mode == 1 && start) begin
      book_busy <= 1'b1;
      busy_left <= 9;
    end else if (busy_left != 0) begin
      busy_left <= busy_left - 1;
    end else begin
      book_busy <= 1'b0;
    end
  end

  always @(negedge clk_100mhz) begin
    if (start) obs_q.push_back({request, delete, stock_to_add, price, order_id, quantity});
  end

  function automatic logic [CMD_W-1:0] cmd(input logic [2:0] req, input logic del, input int stk,
                                           input logic [15:0] pr, input int id);
    return {req, del, SW'(stk), pr, 8'(id), 8'd1};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_snapshot(input int snap, input int id, input bit with_cancel, input int prev_snap);
    if (with_cancel)
      for (int st = 0; st < NS; st++) exp_q.push_back(cmd(CANCEL_ORDER, 1'b1, st, rom_price(prev_snap, NS - 1), id - 1));
    for (int st = 0; st < NS; st++) exp_q.push_back(cmd(ADD_ORDER, 1'b0, st, rom_price(snap, st), id));
  endtask

  task automatic compare_cmds(input string tag);
    int i;
    check({tag, " count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    i = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      check($sformatf("%s cmd%0d", tag, i), 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
      i++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // what: 0 = seq_busy high, 1 = seq_busy low, 2 = in ADD_WAIT, 3 = done
  task automatic wait_for(input int what, input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk_100mhz);
      case (what)
        0:       ok = seq_busy;
        1:       ok = !seq_busy;
        2:       ok = (state_dbg == S_ADD_WAIT);
        default: ok = done;
      endcase
      if (ok) break;
    end
    check({tag, " reached"}, 64'(ok), 64'(1));
  endtask

  task automatic pulse_step();
    @(negedge clk_100mhz);
    step_pulse = 1'b1;
    @(negedge clk_100mhz);
    step_pulse = 1'b0;
  endtask

  initial begin
    int elapsed;
    int hold_len;
    int exp_snap[4];
    exp_snap = '{1, 2, 0, 1};

    // Reset state
    repeat (3) @(negedge clk_100mhz);
    rst = 1'b0;
    @(negedge clk_100mhz);
    check("reset start", 64'(start), 64'(0));
    check("reset outputs", 64'({rom_rd_en, rom_addr, request, delete, stock_to_add, price, order_id,
                                quantity, snapshot_idx, seq_busy, done, timeout_err}), 64'(0));
    check("reset state", 64'(state_dbg), 64'(0));

    // First snapshot: adds only, id 1
    expect_snapshot(0, 1, 1'b0, 0);
    run = 1'b1;
    wait_for(0, "snap0 busy", 50);
    wait_for(1, "snap0 hold", 200);
    check("snap0 state", 64'(state_dbg), 64'(S_HOLD));
    check("snap0 idx", 64'(snapshot_idx), 64'(0));
    check("snap0 done", 64'(done), 64'(0));
    compare_cmds("snap0");

    // Manual step: cancels id 1, adds id 2
    expect_snapshot(1, 2, 1'b1, 0);
    pulse_step();
    wait_for(0, "snap1 busy", 50);
    wait_for(1, "snap1 hold", 300);
    check("snap1 idx", 64'(snapshot_idx), 64'(1));
    compare_cmds("snap1");

    // Slow book, plus a step pulse mid-sequence that must be dropped
    busy_mode = 1;
    expect_snapshot(2, 3, 1'b1, 1);
    pulse_step();
    wait_for(0, "snap2 busy", 50);
    repeat (5) @(negedge clk_100mhz);
    pulse_step();
    wait_for(1, "snap2 hold", 1000);
    repeat (5) @(negedge clk_100mhz);
    check("snap2 stays hold", 64'(seq_busy), 64'(0));
    check("snap2 idx", 64'(snapshot_idx), 64'(2));
    check("no start while busy", 64'(overlap_cnt), 64'(0));
    check("no timeout slow book", 64'(timeout_err), 64'(0));
    compare_cmds("snap2");

    // Stuck busy: each command times out, sequence wraps to snapshot 0
    busy_mode = 2;
    repeat (2) @(negedge clk_100mhz);
    expect_snapshot(0, 4, 1'b1, 2);
    pulse_step();
    wait_for(0, "wrap busy", 50);
    elapsed = 0;
    while (seq_busy && elapsed < 1000) begin
      @(negedge clk_100mhz);
      elapsed++;
    end
    check("timeout duration", 64'(elapsed >= 8 * TO), 64'(1));
    check("timeout_err set", 64'(timeout_err), 64'(1));
    check("wrap idx", 64'(snapshot_idx), 64'(0));
    busy_mode = 0;
    interval = 21'd100;
    mode_auto = 1'b1;
    repeat (5) @(negedge clk_100mhz);
    check("timeout_err sticky", 64'(timeout_err), 64'(1));
    compare_cmds("wrap");

    // Auto mode with looping: 1, 2, 0, 1
    expect_snapshot(1, 5, 1'b1, 0);
    expect_snapshot(2, 6, 1'b1, 1);
    expect_snapshot(0, 7, 1'b1, 2);
    expect_snapshot(1, 8, 1'b1, 0);
    for (int k = 0; k < 4; k++) begin
      wait_for(0, $sformatf("auto%0d busy", k), 400);
      wait_for(1, $sformatf("auto%0d hold", k), 400);
      check($sformatf("auto%0d idx", k), 64'(snapshot_idx), 64'(exp_snap[k]));
      if (k < 3) begin
        hold_len = 1;
        while (hold_len < 400) begin
          @(negedge clk_100mhz);
          step_pulse = (k == 1 && hold_len == 2);
          if (seq_busy) break;
          hold_len++;
        end
        step_pulse = 1'b0;
        check($sformatf("auto%0d dwell", k), 64'(hold_len >= 100), 64'(1));
      end
    end

    // No looping: one more snapshot, then DONE
    loop_en = 1'b0;
    expect_snapshot(2, 9, 1'b1, 1);
    wait_for(3, "done", 600);
    check("done idx", 64'(snapshot_idx), 64'(2));
    check("done seq_busy", 64'(seq_busy), 64'(0));
    check("done cmd outputs", 64'({request, delete, stock_to_add, price, order_id, quantity}), 64'(0));
    compare_cmds("auto");
    repeat (200) @(negedge clk_100mhz);
    check("done no starts", 64'(obs_q.size()), 64'(0));
    check("done held", 64'(done), 64'(1));

    // Reset during ADD_WAIT of snapshot 1, then replay from scratch
    rst = 1'b1;
    repeat (2) @(negedge clk_100mhz);
    rst = 1'b0;
    mode_auto = 1'b0;
    loop_en = 1'b1;
    busy_mode = 1;
    obs_q.delete();
    expect_snapshot(0, 1, 1'b0, 0);
    wait_for(0, "rr snap0 busy", 50);
    wait_for(1, "rr snap0 hold", 1000);
    for (int st = 0; st < NS; st++) exp_q.push_back(cmd(CANCEL_ORDER, 1'b1, st, rom_price(0, NS - 1), 1));
    exp_q.push_back(cmd(ADD_ORDER, 1'b0, 0, rom_price(1, 0), 2));
    pulse_step();
    wait_for(2, "rr add_wait", 1000);
    check("rr idx before reset", 64'(snapshot_idx), 64'(1));
    rst = 1'b1;
    @(negedge clk_100mhz);
    check("rr start", 64'(start), 64'(0));
    check("rr outputs", 64'({rom_rd_en, rom_addr, request, delete, stock_to_add, price, order_id,
                             quantity, snapshot_idx, seq_busy, done, timeout_err}), 64'(0));
    check("rr state", 64'(state_dbg), 64'(0));
    rst = 1'b0;
    expect_snapshot(0, 1, 1'b0, 0);
    wait_for(0, "rr replay busy", 50);
    wait_for(1, "rr replay hold", 1000);
    check("rr replay idx", 64'(snapshot_idx), 64'(0));
    compare_cmds("rr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
